// File: rtl/updown_pkg.sv
// Shared definitions for the up/down sweep controller.
//   - FSM state encoding (3-bit)
//   - default counter width, sweep counter width
//   - counter direction polarity for the select output
package updown_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned SWEEP_W   = 8;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    DWELL_HI = 3'd2,
    DOWN     = 3'd3,
    DWELL_LO = 3'd4
  } state_e;

endpackage

// File: rtl/updown_sweep_ctrl_dwell_timer.sv
// Loadable down-counter used to time the pause at each sweep limit.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : load i_load_val (has priority over i_dec)
//   i_dec          : decrement, saturating at zero
//   o_zero_c       : combinational flag, count is zero
module dwell_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Direction/enable controller for a WIDTH-bit up/down counter. Reads the
// counter value back and ping-pongs it between latched low/high limits,
// pausing DWELL_CYC cycles at each turnaround, for NUM_SWEEPS sweeps.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_start, i_stop     : run request (IDLE only) / abort (highest priority)
//   i_lo_lim, i_hi_lim  : sweep limits, latched on an accepted start
//   i_q                 : counter value feedback
//   o_select            : counter direction (1 up, 0 down), registered
//   o_cnt_en            : counter step enable, combinational (Mealy)
//   o_at_lim, o_done    : one-cycle pulses on limit arrival / run completion
//   o_busy              : high in any state other than IDLE
//   o_err               : sticky out-of-bounds flag, only with
//                         UPDOWN_SWEEP_CTRL_BOUND_CHK_EN defined
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DWELL_CYC  = 2,
  parameter int unsigned NUM_SWEEPS = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [WIDTH-1:0] i_lo_lim,
  input  logic [WIDTH-1:0] i_hi_lim,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_select,
  output logic             o_cnt_en,
  output logic             o_at_lim,
  output logic             o_done,
  output logic             o_busy
`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
  ,
  output logic             o_err
`endif
);

  localparam int unsigned DW_W       = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned DWELL_LOAD = (DWELL_CYC == 0) ? 0 : DWELL_CYC - 1;

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [SWEEP_W-1:0] r_sweep, w_sweep_nxt, w_sweep_inc;
  logic               r_select, w_select_nxt;
  logic               r_at_lim, w_at_lim_nxt;
  logic               r_done, w_done_nxt;
  logic               r_busy;
  logic               w_dwell_load, w_dwell_dec, w_dwell_zero;
  logic               w_start_acc;

  assign w_start_acc = (r_state == IDLE) && i_start && (i_lo_lim < i_hi_lim);

  dwell_timer #(.CNT_W(DW_W)) u_dwell (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_dwell_load),
    .i_load_val (DW_W'(DWELL_LOAD)),
    .i_dec      (w_dwell_dec),
    .o_zero_c   (w_dwell_zero)
  );

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_sweep  <= '0;
      r_select <= DIR_UP;
      r_at_lim <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_sweep  <= w_sweep_nxt;
      r_select <= w_select_nxt;
      r_at_lim <= w_at_lim_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  // Next-state, registered-output next values and the Mealy step enable
  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_sweep_nxt  = r_sweep;
    w_sweep_inc  = r_sweep + SWEEP_W'(1);
    w_select_nxt = r_select;
    w_at_lim_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_dwell_load = 1'b0;
    w_dwell_dec  = 1'b0;
    o_cnt_en     = 1'b0;

    // Abort beats limit arrival: no step, no at_lim, run bookkeeping cleared
    if ((r_state != IDLE) && i_stop) begin
      w_state_nxt  = IDLE;
      w_sweep_nxt  = '0;
      w_select_nxt = DIR_UP;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            w_lo_nxt = i_lo_lim;
            w_hi_nxt = i_hi_lim;
            if (i_q < i_hi_lim) begin
              w_state_nxt  = UP;
              w_select_nxt = DIR_UP;
            end else begin
              w_state_nxt  = DOWN;
              w_select_nxt = DIR_DN;
            end
          end
        end
        UP: begin
          if (i_q != r_hi) begin
            o_cnt_en = 1'b1;
          end else begin
            w_at_lim_nxt = 1'b1;
            w_select_nxt = DIR_DN;
            if (DWELL_CYC != 0) begin
              w_state_nxt  = DWELL_HI;
              w_dwell_load = 1'b1;
            end else begin
              w_state_nxt  = DOWN;
            end
          end
        end
        DWELL_HI: begin
          if (w_dwell_zero) w_state_nxt = DOWN;
          else              w_dwell_dec = 1'b1;
        end
        DOWN: begin
          if (i_q != r_lo) begin
            o_cnt_en = 1'b1;
          end else begin
            w_at_lim_nxt = 1'b1;
            w_select_nxt = DIR_UP;
            if (w_sweep_inc == SWEEP_W'(NUM_SWEEPS)) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_sweep_nxt = '0;
            end else begin
              w_sweep_nxt = w_sweep_inc;
              if (DWELL_CYC != 0) begin
                w_state_nxt  = DWELL_LO;
                w_dwell_load = 1'b1;
              end else begin
                w_state_nxt  = UP;
              end
            end
          end
        end
        DWELL_LO: begin
          if (w_dwell_zero) w_state_nxt = UP;
          else              w_dwell_dec = 1'b1;
        end
        default: begin
          w_state_nxt  = IDLE;
          w_select_nxt = DIR_UP;
        end
      endcase
    end
  end

  assign o_select = r_select;
  assign o_at_lim = r_at_lim;
  assign o_done   = r_done;
  assign o_busy   = r_busy;

`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
  logic r_err;
  logic r_first;

  // Sticky bound check; the first cycle of a run is skipped since q may
  // legitimately start outside the limits
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_first <= w_start_acc;
      if (w_start_acc) begin
        r_err <= 1'b0;
      end else if ((r_state != IDLE) && !r_first && ((i_q < r_lo) || (i_q > r_hi))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: three instances with different dwell/sweep
// settings, each closing the loop through a behavioural 4-bit up/down
// counter. Expected per-cycle traces are generated from the sweep rules.
module tb_updown_sweep_ctrl;

  localparam int DWELL_OF [3] = '{2, 0, 2};
  localparam int NSW_OF   [3] = '{1, 2, 3};

  typedef struct {
    int q;
    bit sel;
    bit en;
    bit atl;
    bit dn;
    bit bsy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start [3];
  logic       stop  [3];
  logic [3:0] lo_lim, hi_lim;
  logic [3:0] cq    [3];
  logic       ld    [3];
  logic [3:0] ld_val;
  logic       sel   [3];
  logic       en    [3];
  logic       atl   [3];
  logic       dn    [3];
  logic       bsy   [3];
`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
  logic       err   [3];
`endif

  exp_t exp_q[$];
  exp_t cur;
  int   act;
  int   cyc_i;
  int   n_chk;
  int   n_pass;
  int   done_cnt [3] = '{0, 0, 0};

  updown_sweep_ctrl #(.WIDTH(4), .DWELL_CYC(DWELL_OF[0]), .NUM_SWEEPS(NSW_OF[0])) dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start[0]), .i_stop(stop[0]),
    .i_lo_lim(lo_lim), .i_hi_lim(hi_lim), .i_q(cq[0]),
    .o_select(sel[0]), .o_cnt_en(en[0]), .o_at_lim(atl[0]), .o_done(dn[0]), .o_busy(bsy[0])
`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
    , .o_err(err[0])
`endif
  );

  updown_sweep_ctrl #(.WIDTH(4), .DWELL_CYC(DWELL_OF[1]), .NUM_SWEEPS(NSW_OF[1])) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start[1]), .i_stop(stop[1]),
    .i_lo_lim(lo_lim), .i_hi_lim(hi_lim), .i_q(cq[1]),
    .o_select(sel[1]), .o_cnt_en(en[1]), .o_at_lim(atl[1]), .o_done(dn[1]), .o_busy(bsy[1])
`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
    , .o_err(err[1])
`endif
  );

  updown_sweep_ctrl #(.WIDTH(4), .DWELL_CYC(DWELL_OF[2]), .NUM_SWEEPS(NSW_OF[2])) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start[2]), .i_stop(stop[2]),
    .i_lo_lim(lo_lim), .i_hi_lim(hi_lim), .i_q(cq[2]),
    .o_select(sel[2]), .o_cnt_en(en[2]), .o_at_lim(atl[2]), .o_done(dn[2]), .o_busy(bsy[2])
`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
    , .o_err(err[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The counter being controlled: steps on edges where cnt_en is high
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst)        cq[d] <= 4'd0;
      else if (ld[d]) cq[d] <= ld_val;
      else if (en[d]) cq[d] <= sel[d] ? cq[d] + 4'd1 : cq[d] - 4'd1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) if (dn[d] === 1'b1) done_cnt[d] = done_cnt[d] + 1;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, e);
  endtask

  // Per-cycle comparison against the generated trace
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk($sformatf("d%0d c%0d q",      act, cyc_i), 32'(cq[act]),  32'(cur.q));
      chk($sformatf("d%0d c%0d select", act, cyc_i), 32'(sel[act]), 32'(cur.sel));
      chk($sformatf("d%0d c%0d cnt_en", act, cyc_i), 32'(en[act]),  32'(cur.en));
      chk($sformatf("d%0d c%0d at_lim", act, cyc_i), 32'(atl[act]), 32'(cur.atl));
      chk($sformatf("d%0d c%0d done",   act, cyc_i), 32'(dn[act]),  32'(cur.dn));
      chk($sformatf("d%0d c%0d busy",   act, cyc_i), 32'(bsy[act]), 32'(cur.bsy));
      cyc_i++;
    end
  end

  function automatic exp_t mk(int q, bit s, bit e, bit a, bit d, bit b);
    exp_t r;
    r.q = q; r.sel = s; r.en = e; r.atl = a; r.dn = d; r.bsy = b;
    return r;
  endfunction

  // Walk the sweep leg by leg; entry 0 is the cycle after the start edge
  task automatic build_trace(input int d, input int q0, input int lo, input int hi, input int keep);
    int q  = q0;
    int sw = 0;
    bit up = (q0 < hi);
    bit pend = 0;
    bit fin = 0;
    while (!fin) begin
      if (up) begin
        while (q < hi) begin exp_q.push_back(mk(q, 1, 1, pend, 0, 1)); pend = 0; q++; end
        exp_q.push_back(mk(q, 1, 0, pend, 0, 1)); pend = 1;
        repeat (DWELL_OF[d]) begin exp_q.push_back(mk(q, 0, 0, pend, 0, 1)); pend = 0; end
        up = 0;
      end else begin
        while (q > lo) begin exp_q.push_back(mk(q, 0, 1, pend, 0, 1)); pend = 0; q--; end
        exp_q.push_back(mk(q, 0, 0, pend, 0, 1)); pend = 1;
        sw++;
        if (sw == NSW_OF[d]) begin
          exp_q.push_back(mk(q, 1, 0, 1, 1, 0));
          exp_q.push_back(mk(q, 1, 0, 0, 0, 0));
          fin = 1;
        end else begin
          repeat (DWELL_OF[d]) begin exp_q.push_back(mk(q, 1, 0, pend, 0, 1)); pend = 0; end
          up = 1;
        end
      end
    end
    if (keep >= 0) while (exp_q.size() > keep) void'(exp_q.pop_back());
  endtask

  // Preload the counter, pulse start, then arm the trace (ends #1 into cycle 0)
  task automatic start_run(input int d, input int q0, input int lo, input int hi, input int keep);
    @(posedge clk); #1;
    ld[d] = 1'b1; ld_val = 4'(q0);
    @(posedge clk); #1;
    ld[d] = 1'b0; lo_lim = 4'(lo); hi_lim = 4'(hi); start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    act   = d;
    cyc_i = 0;
    build_trace(d, q0, lo, hi, keep);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    #1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk($sformatf("%s d%0d busy",   tag, d), 32'(bsy[d]), 32'd0);
    chk($sformatf("%s d%0d select", tag, d), 32'(sel[d]), 32'd1);
    chk($sformatf("%s d%0d cnt_en", tag, d), 32'(en[d]),  32'd0);
    chk($sformatf("%s d%0d at_lim", tag, d), 32'(atl[d]), 32'd0);
    chk($sformatf("%s d%0d done",   tag, d), 32'(dn[d]),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int base;
    n_chk = 0; n_pass = 0; act = 0; cyc_i = 0;
    rst = 1'b1; lo_lim = '0; hi_lim = '0; ld_val = '0;
    for (int d = 0; d < 3; d++) begin start[d] = 1'b0; stop[d] = 1'b0; ld[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_idle(d, "reset");
`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
      chk($sformatf("reset d%0d err", d), 32'(err[d]), 32'd0);
`endif
    end
    rst = 1'b0;

    // Basic sweep: 2..5 with a 2-cycle dwell, one sweep
    base = done_cnt[0];
    start_run(0, 2, 2, 5, -1);
    chk("basic trace_len", 32'(exp_q.size()), 32'd12);
    chk("basic trace_q3", 32'(exp_q[3].q), 32'd5);
    chk("basic trace_done10", 32'(exp_q[10].dn), 32'd1);
    drain();
    chk("basic end_q", 32'(cq[0]), 32'd2);
    chk("basic end_busy", 32'(bsy[0]), 32'd0);
    chk("basic done_pulses", 32'(done_cnt[0] - base), 32'd1);

    // Illegal limits: equal and inverted
    lo_lim = 4'd7; hi_lim = 4'd7; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk_idle(0, "lo_eq_hi");
    lo_lim = 4'd9; hi_lim = 4'd3; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    chk_idle(0, "lo_gt_hi");

    // Second start with new limits while busy is ignored
    start_run(0, 2, 2, 5, -1);
    repeat (2) @(posedge clk);
    #1;
    lo_lim = 4'd0; hi_lim = 4'd9; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    drain();
    chk("busy_start end_q", 32'(cq[0]), 32'd2);

    // Immediate reverse over the full range, two sweeps
    base = done_cnt[1];
    start_run(1, 0, 0, 15, -1);
    chk("full trace_len", 32'(exp_q.size()), 32'd66);
    drain();
    chk("full done_pulses", 32'(done_cnt[1] - base), 32'd1);
    chk("full end_q", 32'(cq[1]), 32'd0);

    // Start above the range: first leg goes down
    start_run(1, 12, 3, 8, -1);
    chk("above select_c0", 32'(sel[1]), 32'd0);
    chk("above busy_c0", 32'(bsy[1]), 32'd1);
    chk("above trace_len", 32'(exp_q.size()), 32'd24);
    drain();
    chk("above end_q", 32'(cq[1]), 32'd3);

    // Stop coincident with arrival at hi in the second sweep's up leg
    base = done_cnt[2];
    start_run(2, 2, 2, 5, 15);
    drain();
    chk("stop q_at_hi", 32'(cq[2]), 32'd5);
    stop[2] = 1'b1;
    #1;
    chk("stop cnt_en", 32'(en[2]), 32'd0);
    @(posedge clk); #1;
    stop[2] = 1'b0;
    chk_idle(2, "after_stop");
    @(posedge clk); #1;
    chk_idle(2, "after_stop2");
    chk("stop q_held", 32'(cq[2]), 32'd5);
    chk("stop no_done", 32'(done_cnt[2] - base), 32'd0);

    // Fresh run after stop needs all three sweeps (sweep count was cleared)
    start_run(2, 5, 2, 5, -1);
    drain();

    // Reset during DWELL_LO
    start_run(2, 2, 2, 5, 10);
    drain();
    chk("dwell_lo select", 32'(sel[2]), 32'd1);
    chk("dwell_lo at_lim", 32'(atl[2]), 32'd1);
    chk("dwell_lo busy", 32'(bsy[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle(2, "mid_reset");
    start_run(2, 2, 2, 5, -1);
    drain();

`ifdef UPDOWN_SWEEP_CTRL_BOUND_CHK_EN
    // Counter forced above hi mid-run: err sets and stays until next start
    start_run(2, 2, 2, 8, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("err before", 32'(err[2]), 32'd0);
    ld_val = 4'd9; ld[2] = 1'b1;
    @(posedge clk); #1;
    ld[2] = 1'b0;
    @(posedge clk); #1;
    chk("err set", 32'(err[2]), 32'd1);
    stop[2] = 1'b1;
    @(posedge clk); #1;
    stop[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("err sticky", 32'(err[2]), 32'd1);
    start_run(2, 2, 2, 8, 0);
    chk("err cleared", 32'(err[2]), 32'd0);
    stop[2] = 1'b1;
    @(posedge clk); #1;
    stop[2] = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
